// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state and op encodings for mult_div_unit.
package mult_div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/cond_negate.sv
// cond_negate: combinational two's-complement negate when neg is set.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle shift-add multiplier / restoring divider with HI/LO result registers.
// Define MULT_DIV_SIGNED_EN to honour the sign input (sign-magnitude operands, FIX correction).
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    stateT state, stateNext;
    logic opReg, zeroPend, accept, isZeroDiv;
    logic [CW-1:0] count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd, aMag, bMag, loRes, hiRes;
    logic [WIDTH:0] addSum, trial;
    assign accept = start && state == IDLE && !zeroPend;
    assign isZeroDiv = op == OP_DIV && b == '0;
    assign addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
`ifdef MULT_DIV_SIGNED_EN
    logic negQ, negR;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0] quotFix, remFix;
    cond_negate #(.WIDTH(WIDTH)) uNegA (.neg(sign & a[WIDTH-1]), .x(a), .y(aMag));
    cond_negate #(.WIDTH(WIDTH)) uNegB (.neg(sign & b[WIDTH-1]), .x(b), .y(bMag));
    cond_negate #(.WIDTH(2*WIDTH)) uNegP (.neg(negQ), .x(acc), .y(prodFix));
    cond_negate #(.WIDTH(WIDTH)) uNegQ (.neg(negQ), .x(acc[WIDTH-1:0]), .y(quotFix));
    cond_negate #(.WIDTH(WIDTH)) uNegR (.neg(negR), .x(acc[2*WIDTH-1:WIDTH]), .y(remFix));
    assign loRes = opReg == OP_DIV ? quotFix : prodFix[WIDTH-1:0];
    assign hiRes = opReg == OP_DIV ? remFix : prodFix[2*WIDTH-1:WIDTH];
`else
    logic unusedSign;
    assign unusedSign = sign;
    assign aMag = a;
    assign bMag = b;
    assign loRes = acc[WIDTH-1:0];
    assign hiRes = acc[2*WIDTH-1:WIDTH];
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= stateNext;
    end
    always_comb begin
        stateNext = (state == IDLE) ? ((accept && !isZeroDiv) ? CALC : IDLE)
                  : (state == CALC) ? ((count == CW'(1)) ? FIX : CALC) : IDLE;
    end
    // Divide by zero stays IDLE; zeroPend delays done/div_zero by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opReg <= 1'b0;
            zeroPend <= 1'b0;
            count <= '0;
            acc <= '0;
            opnd <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            div_zero <= 1'b0;
            hi <= '0;
            lo <= '0;
`ifdef MULT_DIV_SIGNED_EN
            negQ <= 1'b0;
            negR <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            zeroPend <= 1'b0;
            if (zeroPend) begin
                done <= 1'b1;
                div_zero <= 1'b1;
            end
            if (accept) begin
                opReg <= op;
                div_zero <= 1'b0;
                zeroPend <= isZeroDiv;
                busy <= !isZeroDiv;
                count <= CW'(WIDTH);
                acc <= {{WIDTH{1'b0}}, (op == OP_DIV ? aMag : bMag)};
                opnd <= op == OP_DIV ? bMag : aMag;
`ifdef MULT_DIV_SIGNED_EN
                negQ <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                negR <= sign & a[WIDTH-1];
`endif
            end
            if (state == CALC) begin
                count <= count - CW'(1);
                acc <= opReg == OP_MULT ? {addSum, acc[WIDTH-1:1]}
                     : trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                     : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
            if (state == FIX) begin
                hi <= hiRes;
                lo <= loRes;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table, directed and random checks of mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
    import mult_div_pkg::*;
    logic clk = 1'b0;
    logic reset, start, op, sign, busy, done, div_zero;
    logic [31:0] a, b, hi, lo;
    logic [31:0] expHi, expLo;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic op;
        logic sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vecT;
    vecT vecs[8];
    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero like the unit.
    task automatic model(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y, output logic dz);
        logic signed [63:0] sx, sy, r;
        bit useSign;
`ifdef MULT_DIV_SIGNED_EN
        useSign = s;
`else
        useSign = 1'b0 & s;
`endif
        if (useSign) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = {32'b0, x};
            sy = {32'b0, y};
        end
        dz = 1'b0;
        if (o == OP_MULT) begin
            r = sx * sy;
            expHi = r[63:32];
            expLo = r[31:0];
        end else if (y == 32'b0) begin
            dz = 1'b1;
        end else begin
            r = sx / sy;
            expLo = r[31:0];
            r = sx % sy;
            expHi = r[31:0];
        end
    endtask
    task automatic launch(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o;
        sign = s;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    task automatic runOp(input string tag, input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
        int lat, busyCnt;
        logic dz;
        model(o, s, x, y, dz);
        launch(o, s, x, y);
        lat = 0;
        busyCnt = 0;
        while (!done && lat < 100) begin
            if (busy) busyCnt++;
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 64'(lat), dz ? 64'd1 : 64'd33);
        check({tag, " busy cycles"}, 64'(busyCnt), dz ? 64'd0 : 64'd33);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(expHi));
        check({tag, " lo"}, 64'(lo), 64'(expLo));
        check({tag, " div_zero"}, 64'(div_zero), 64'(dz));
    endtask
    initial begin
        int dones;
        logic [31:0] ra, rb;
        vecs[0] = '{OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42};
        vecs[2] = '{OP_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14};
`ifdef MULT_DIV_SIGNED_EN
        vecs[3] = '{OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[4] = '{OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        vecs[6] = '{OP_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
`else
        vecs[3] = '{OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1};
        vecs[4] = '{OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC};
        vecs[5] = '{OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
        vecs[6] = '{OP_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0};
`endif
        vecs[7] = '{OP_DIV, 1'b0, 32'h56781234, 32'h00010000, 32'h1234, 32'h5678};
        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        sign = 1'b0;
        a = '0;
        b = '0;
        expHi = '0;
        expLo = '0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Back-to-back: each launch falls in the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d table hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d table lo", i), 64'(lo), 64'(vecs[i].lo));
        end
        runOp("divzero", OP_DIV, 1'b0, 32'd5, 32'd0);
        check("divzero table hi", 64'(hi), 64'h1234);
        check("divzero table lo", 64'(lo), 64'h5678);
        @(posedge clk);
        #1;
        check("divzero done one cycle", 64'(done), 64'd0);
        check("divzero flag held", 64'(div_zero), 64'd1);
        runOp("after divzero", OP_MULT, 1'b0, 32'd2, 32'd3);
        // A second start five cycles in must be ignored.
        model(OP_MULT, 1'b0, 32'h1111, 32'd3, rb[0]);
        launch(OP_MULT, 1'b0, 32'h1111, 32'd3);
        repeat (4) @(posedge clk);
        launch(OP_DIV, 1'b0, 32'd9, 32'd0);
        dones = 0;
        repeat (60) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        check("ignored start done count", 64'(dones), 64'd1);
        check("ignored start hi", 64'(hi), 64'h0);
        check("ignored start lo", 64'(lo), 64'h3333);
        check("ignored start div_zero", 64'(div_zero), 64'd0);
        // Asynchronous reset at CALC iteration 10.
        launch(OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset div_zero", 64'(div_zero), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        expHi = '0;
        expLo = '0;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done || busy) dones++;
        end
        check("midreset discarded", 64'(dones), 64'd0);
        runOp("post reset 6x7", OP_MULT, 1'b0, 32'd6, 32'd7);
        check("post reset lo", 64'(lo), 64'd42);
        check("post reset hi", 64'(hi), 64'd0);
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom();
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            if ($urandom_range(0, 9) == 0) rb = 32'hFFFFFFFF;
            runOp($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit that computes a double-width product or a quotient/remainder pair and holds the result in internal HI/LO registers. It sits beside the ALU in the multicycle datapath. The control unit launches an operation with a one-cycle `start` pulse, stalls on `busy`, and writes HI/LO to the register file through the write-data mux once `done` is seen. It replaces a fixed 32-bit unit: width is a parameter, and division by zero is flagged.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be at least 2. HI and LO are each WIDTH bits wide.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: launch request. Sampled only while the unit is idle.
- `op`  in  1: 0 = multiply, 1 = divide. Sampled with `start`.
- `sign`  in  1: 1 = signed operation (mult/div), 0 = unsigned (multu/divu). Sampled with `start`.
- `a`  in  WIDTH: multiplicand, or dividend for a divide.
- `b`  in  WIDTH: multiplier, or divisor for a divide.
- `busy`  out  1: an operation is in progress.
- `done`  out  1: one-cycle pulse marking that a result is valid.
- `div_zero`  out  1: the last divide had `b` = 0. Held until the next accepted `start`.
- `hi`  out  WIDTH: upper half of the product, or the remainder.
- `lo`  out  WIDTH: lower half of the product, or the quotient.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - `start` = 1 latches `op`, `sign`, `a`, `b`; clears `div_zero`; goes to CALC and sets `busy`.
  - Exception: a divide with `b` = 0 goes straight to IDLE. At the next edge it pulses `done` and sets `div_zero`. HI/LO are unchanged and `busy` never asserts.
- **CALC:** WIDTH iterations, one per cycle, on operand magnitudes.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - An iteration counter of `$clog2(WIDTH)+1` bits counts down. Leave CALC when it reaches 0.
- **FIX:**
  - Apply sign correction and write HI/LO. Pulse `done`, clear `busy`, return to IDLE.
  - Multiply: negate the 2·WIDTH product when operand signs differ.
  - Divide: negate the quotient when signs differ. The remainder takes the sign of the dividend.
- **Signed MIN / −1:** quotient wraps to MIN (`10…0`), remainder 0. No flag is raised.
- `start` while `busy` = 1 is ignored, with no queueing.
- `start` in the cycle where `done` is high is accepted, because the unit is already IDLE.
- HI/LO hold their value between operations and change only in FIX.
- **Reset:** asserting `reset`, including mid-operation, immediately gives state IDLE, `busy` = 0, `done` = 0, `div_zero` = 0, `hi` = 0, `lo` = 0. The operation in flight is discarded.

## Timing
- Let E0 be the edge that samples `start`. E1…E_WIDTH are the CALC iterations. HI/LO are written at E_(WIDTH+1).
- `busy` is high from after E0 until after E_(WIDTH+1).
- `done` is high for exactly one cycle after E_(WIDTH+1). Latency is WIDTH+1 cycles: 33 when WIDTH = 32.
- For a divide by zero, `done` and `div_zero` are visible after E1, a latency of 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`MULT_DIV_SIGNED_EN` defined:** the `sign` input is honoured, giving the sign-magnitude handling and FIX correction above.
- **`MULT_DIV_SIGNED_EN` undefined:**
  - `sign` is ignored and all operations are unsigned.
  - FIX only writes HI/LO; no negation logic is synthesised.
  - Latency is unchanged.

## Structure
- **Package `mult_div_pkg`:**
  - state enum `{IDLE, CALC, FIX}`;
  - `op` encoding constants `OP_MULT` = 0 and `OP_DIV` = 1.
- **Sub-module `cond_negate`:** parametrised width, outputs `neg ? -x : x`, combinational.
  - Used for taking operand magnitudes and for the FIX correction.
  - Excluded when `MULT_DIV_SIGNED_EN` is undefined.

## Test plan
All scenarios use WIDTH = 32.
- Unsigned multiply `0xFFFFFFFF` × `0xFFFFFFFF` → `hi` = `0xFFFFFFFE`, `lo` = `0x00000001`, `done` 33 cycles after `start`, `busy` high throughout.
- Signed multiply −3 × 5 → `hi` = `0xFFFFFFFF`, `lo` = `0xFFFFFFF1`. With the macro undefined, the same stimulus gives `hi` = `0x00000004`, `lo` = `0xFFFFFFF1`.
- Signed divide −7 / 2 → `lo` = `0xFFFFFFFD`, `hi` = `0xFFFFFFFF`. Signed divide `0x80000000` / `0xFFFFFFFF` → `lo` = `0x80000000`, `hi` = 0.
- Divide 5 / 0 after a prior result `hi` = `0x1234`, `lo` = `0x5678` → `done` and `div_zero` set 1 cycle after `start`, `busy` never asserts, HI/LO keep `0x1234` / `0x5678`.
- Pulse `start` again 5 cycles into an operation → ignored; results match the first operands, and exactly one `done` pulse occurs.
- Assert `reset` at CALC iteration 10 → all outputs 0 immediately. A new multiply 6 × 7 after release gives `lo` = 42, `hi` = 0.
